// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave
//  Purpose  : Byte-oriented SPI target for one chip-select line. The SPI pins
//             are oversampled in the i_clk domain. All four SPI modes, bit
//             order and CS polarity are selected by a 4-bit config word.
//  Ports    : i_clk, i_rst_n          system clock, async active-low reset
//             i_config_data[3:0]      [3]=CPOL [2]=CPHA [1]=LSB-first
//                                     [0]=CS active-high
//             i_tx_data_valid/_byte   TX holding-register write
//             o_tx_ready              holding register empty
//             o_tx_underrun           frame/byte started with nothing queued
//             o_rx_data_valid/_byte   received byte strobe and data
//             o_busy                  chip select active
//             i_spi_sclk/cs/mosi      SPI inputs (asynchronous)
//             o_spi_miso, o_spi_miso_oe  SPI output and its enable
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TX_DEFAULT  = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_config_data,
    input  logic       i_tx_data_valid,
    input  logic [7:0] i_tx_data_byte,
    output logic       o_tx_ready,
    output logic       o_tx_underrun,
    output logic       o_rx_data_valid,
    output logic [7:0] o_rx_data_byte,
    output logic       o_busy,
    input  logic       i_spi_sclk,
    input  logic       i_spi_cs,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    output logic       o_spi_miso_oe
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                 state_q,       state_d;
    logic [3:0]             cfg_q,         cfg_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q,   sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,     cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q,   mosi_sync_d;
    logic                   sclk_prev_q,   sclk_prev_d;
    logic [2:0]             bit_cnt_q,     bit_cnt_d;
    logic [7:0]             rx_shift_q,    rx_shift_d;
    logic [7:0]             tx_shift_q,    tx_shift_d;
    logic [7:0]             hold_q,        hold_d;
    logic                   hold_full_q,   hold_full_d;
    logic                   pend_q,        pend_d;
    logic                   pend_urun_q,   pend_urun_d;
    logic                   rx_done_q,     rx_done_d;
    logic [7:0]             rx_byte_q,     rx_byte_d;
    logic                   rx_valid_q,    rx_valid_d;
    logic                   underrun_q,    underrun_d;

    logic sclk_s, cs_s, mosi_s;
    logic cpol, cpha, lsb_first, cs_high;
    logic cs_act, lead_edge, trail_edge, sample_edge, shift_edge;
    logic [7:0] reload_byte;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cpol      = cfg_q[3];
    assign cpha      = cfg_q[2];
    assign lsb_first = cfg_q[1];
    assign cs_high   = cfg_q[0];

    assign cs_act      = cs_s ^ ~cs_high;
    assign lead_edge   = (sclk_prev_q == cpol) && (sclk_s != cpol);
    assign trail_edge  = (sclk_prev_q != cpol) && (sclk_s == cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge  : trail_edge;
    assign reload_byte = hold_full_q ? hold_q : TX_DEFAULT;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   i_spi_cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
        sclk_prev_d = sclk_s;
        state_d     = state_q;
        cfg_d       = cfg_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        pend_d      = pend_q;
        pend_urun_d = pend_urun_q;
        rx_done_d   = 1'b0;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;

        if (rx_done_q) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cfg_d     = i_config_data;
                bit_cnt_d = 3'd0;
                pend_d    = 1'b0;
                if (cs_act) begin
                    state_d     = ST_ACTIVE;
                    tx_shift_d  = reload_byte;
                    underrun_d  = ~hold_full_q;
                    hold_full_d = 1'b0;
                    rx_shift_d  = 8'h00;
                end
            end
            ST_ACTIVE: begin
                if (!cs_act) begin
                    // Partial byte and any speculative reload are dropped.
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    pend_d    = 1'b0;
                end else if (sample_edge) begin
                    rx_shift_d = lsb_first ? {mosi_s, rx_shift_q[7:1]}
                                           : {rx_shift_q[6:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    // The inter-byte reload is only committed (holding
                    // register consumed or underrun flagged) once the master
                    // actually clocks the next byte, so the byte after the
                    // last one of a CS window never raises a false underrun.
                    if (bit_cnt_q == 3'd0 && pend_q) begin
                        pend_d = 1'b0;
                        if (pend_urun_q) begin
                            underrun_d = 1'b1;
                        end else begin
                            hold_full_d = 1'b0;
                        end
                    end
                    if (bit_cnt_q == 3'd7) begin
                        rx_done_d   = 1'b1;
                        tx_shift_d  = reload_byte;
                        pend_d      = 1'b1;
                        pend_urun_d = ~hold_full_q;
                    end
                end else if (shift_edge && bit_cnt_q != 3'd0) begin
                    // A shift edge seen with bit_cnt==0 either precedes the
                    // first sample (CPHA=1: bit 0 is already on MISO) or
                    // follows the byte's last sample (CPHA=0: reload already
                    // placed the next bit 0); both must leave tx_shift alone.
                    tx_shift_d = lsb_first ? {1'b0, tx_shift_q[7:1]}
                                           : {tx_shift_q[6:0], 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Write after the frame-start reload so a same-cycle write lands in
        // the freshly emptied register instead of the byte being shifted.
        if (i_tx_data_valid && !hold_full_q) begin
            hold_d      = i_tx_data_byte;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cfg_q       <= 4'h0;
            sclk_sync_q <= '0;
            // CS idles high for the reset config (active-low), so the chain
            // starts inactive and no frame is seen right after reset.
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_urun_q <= 1'b0;
            rx_done_q   <= 1'b0;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            pend_q      <= pend_d;
            pend_urun_q <= pend_urun_d;
            rx_done_q   <= rx_done_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign o_tx_ready      = ~hold_full_q;
    assign o_tx_underrun   = underrun_q;
    assign o_rx_data_valid = rx_valid_q;
    assign o_rx_data_byte  = rx_byte_q;
    assign o_busy          = (state_q == ST_ACTIVE);
    assign o_spi_miso_oe   = (state_q == ST_ACTIVE);
    assign o_spi_miso      = (state_q == ST_ACTIVE) &&
                             (lsb_first ? tx_shift_q[0] : tx_shift_q[7]);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave
//  Purpose  : Self-checking bench for spi_slave. A behavioural SPI master
//             (sclk = clk/8) drives directed frames from a vector table plus
//             hand-written multi-byte, aborted-frame and reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cfg;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready, tx_underrun, rx_valid, busy, miso, miso_oe;
    logic [7:0] rx_byte;
    logic       sclk, cs, mosi;

    spi_slave #(.SYNC_STAGES(2), .TX_DEFAULT(8'h00)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_config_data   (cfg),
        .i_tx_data_valid (tx_valid),
        .i_tx_data_byte  (tx_byte),
        .o_tx_ready      (tx_ready),
        .o_tx_underrun   (tx_underrun),
        .o_rx_data_valid (rx_valid),
        .o_rx_data_byte  (rx_byte),
        .o_busy          (busy),
        .i_spi_sclk      (sclk),
        .i_spi_cs        (cs),
        .i_spi_mosi      (mosi),
        .o_spi_miso      (miso),
        .o_spi_miso_oe   (miso_oe)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Pulse monitors
    int         rx_cnt   = 0;
    int         urun_cnt = 0;
    logic [7:0] rx_seen [0:3];

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_cnt < 4) rx_seen[rx_cnt] <= rx_byte;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_underrun) urun_cnt <= urun_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_counts();
        @(negedge clk);
        rx_cnt   = 0;
        urun_cnt = 0;
    endtask

    task automatic set_cfg(input logic [3:0] c);
        cfg  = c;
        sclk = c[3];
        cs   = ~c[0];
        mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b, input string name);
        chk({name, "_ready_before"}, {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b1;
        tx_byte  = b;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        chk({name, "_ready_after"}, {31'd0, tx_ready}, 32'd0);
    endtask

    task automatic cs_assert();
        cs = cfg[0];
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_release();
        repeat (4) @(negedge clk);
        cs = ~cfg[0];
        repeat (8) @(negedge clk);
    endtask

    // Behavioural master: sends nbits of mo in the current cfg's order and
    // captures MISO on the master's sample edge.
    task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        logic cpol, cpha, lsb, bitv;
        cpol = cfg[3];
        cpha = cfg[2];
        lsb  = cfg[1];
        mi   = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            bitv = lsb ? mo[b] : mo[7-b];
            if (!cpha) begin
                mosi = bitv;
                half();
                if (lsb) mi[b] = miso; else mi[7-b] = miso;
                sclk = ~cpol;
                half();
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = bitv;
                half();
                if (lsb) mi[b] = miso; else mi[7-b] = miso;
                sclk = cpol;
                half();
            end
        end
        half();
    endtask

    typedef struct {
        logic [3:0] cfg;
        logic [7:0] mosi;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [7:0] mi, mi2;

        vecs[0] = '{4'b0000, 8'hCB, 8'h5A, 8'hCB, 8'h5A};
        vecs[1] = '{4'b0100, 8'hCB, 8'h3C, 8'hCB, 8'h3C};
        vecs[2] = '{4'b1000, 8'hCB, 8'h3C, 8'hCB, 8'h3C};
        vecs[3] = '{4'b1100, 8'hCB, 8'h3C, 8'hCB, 8'h3C};
        vecs[4] = '{4'b0010, 8'hCB, 8'h01, 8'hCB, 8'h01};
        vecs[5] = '{4'b0001, 8'hA7, 8'hE1, 8'hA7, 8'hE1};
        vecs[6] = '{4'b1110, 8'h35, 8'h9C, 8'h35, 8'h9C};

        rst_n    = 1'b0;
        cfg      = 4'b0000;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        sclk     = 1'b0;
        cs       = 1'b1;
        mosi     = 1'b0;
        repeat (4) @(negedge clk);

        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_outputs", {26'd0, tx_underrun, rx_valid, busy, miso, miso_oe, 1'b0}, 32'd0);
        chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        // Table-driven single-byte frames over all modes / orders / polarities
        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i].cfg);
            clear_counts();
            load_tx(vecs[i].tx, $sformatf("v%0d", i));
            cs_assert();
            chk($sformatf("v%0d_ready_at_cs", i), {31'd0, tx_ready}, 32'd1);
            chk($sformatf("v%0d_oe_busy", i), {30'd0, miso_oe, busy}, 32'd3);
            xfer_bits(vecs[i].mosi, 8, mi);
            cs_release();
            chk($sformatf("v%0d_rx_count", i), rx_cnt, 32'd1);
            chk($sformatf("v%0d_rx_byte", i), {24'd0, rx_seen[0]}, {24'd0, vecs[i].exp_rx});
            chk($sformatf("v%0d_miso", i), {24'd0, mi}, {24'd0, vecs[i].exp_miso});
            chk($sformatf("v%0d_underrun", i), urun_cnt, 32'd0);
            chk($sformatf("v%0d_oe_after", i), {31'd0, miso_oe}, 32'd0);
        end

        // Two bytes in one CS window, only one byte queued; a write while
        // full must be ignored.
        set_cfg(4'b0000);
        clear_counts();
        load_tx(8'h11, "b2b");
        tx_valid = 1'b1;
        tx_byte  = 8'h22;
        @(negedge clk);
        tx_valid = 1'b0;
        cs_assert();
        xfer_bits(8'hA5, 8, mi);
        xfer_bits(8'h96, 8, mi2);
        cs_release();
        chk("b2b_rx_count", rx_cnt, 32'd2);
        chk("b2b_rx0", {24'd0, rx_seen[0]}, 32'h0000_00A5);
        chk("b2b_rx1", {24'd0, rx_seen[1]}, 32'h0000_0096);
        chk("b2b_miso0", {24'd0, mi}, 32'h0000_0011);
        chk("b2b_miso1", {24'd0, mi2}, 32'h0000_0000);
        chk("b2b_underrun", urun_cnt, 32'd1);

        // Aborted 5-bit frame followed by a full frame
        clear_counts();
        cs_assert();
        xfer_bits(8'hFF, 5, mi);
        cs_release();
        chk("abort_rx_count", rx_cnt, 32'd0);
        chk("abort_oe", {30'd0, miso_oe, busy}, 32'd0);
        cs_assert();
        xfer_bits(8'h7E, 8, mi);
        cs_release();
        chk("abort_next_count", rx_cnt, 32'd1);
        chk("abort_next_rx", {24'd0, rx_seen[0]}, 32'h0000_007E);

        // Reset pulsed mid-frame
        clear_counts();
        load_tx(8'hAA, "rst");
        cs_assert();
        xfer_bits(8'hF0, 3, mi);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("midrst_outputs", {27'd0, tx_underrun, rx_valid, busy, miso, miso_oe}, 32'd0);
        chk("midrst_rx_byte", {24'd0, rx_byte}, 32'h0000_007E & 32'h0);
        sclk = 1'b0;
        cs   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        clear_counts();
        cs_assert();
        xfer_bits(8'hCB, 8, mi);
        cs_release();
        chk("postrst_rx_count", rx_cnt, 32'd1);
        chk("postrst_rx", {24'd0, rx_seen[0]}, 32'h0000_00CB);
        chk("postrst_miso_default", {24'd0, mi}, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
